// File: rtl/m_pwm_bank.sv
// m_pwm_bank: multi-channel PWM bank with one shared period counter; new duties apply at the period boundary.
// Optional feature macro PWM_BANK_FADE_EN: active duty steps +/-1 per period toward target instead of jumping.
module m_pwm_bank #(
    parameter int CH      = 16,
    parameter int W       = 4,
    parameter int STAGGER = 1
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            CE,
    input  logic            LOAD,
    input  logic [CH*W-1:0] DAT_I,
    output logic [CH-1:0]   PWM_P,
    output logic [CH-1:0]   PWM_N,
    output logic            PERIOD_END,
    output logic            BUSY
);

    logic [W-1:0]           r_cnt;
    logic [CH-1:0][W-1:0]   r_target;
    logic [CH-1:0][W-1:0]   r_active;
    logic [CH-1:0][W-1:0]   w_target_nxt;
    logic [CH-1:0][W-1:0]   w_active_nxt;
    logic [CH-1:0]          w_pwm;
    logic                   w_boundary;
    logic                   w_busy_nxt;

    assign w_boundary = CE && (r_cnt == {W{1'b1}});

    // Next-state target/active values; BUSY is judged on these so it tracks the post-edge state.
    always_comb begin
        w_busy_nxt = 1'b0;
        for (int i = 0; i < CH; i++) begin
            if (LOAD) begin
                w_target_nxt[i] = DAT_I[i*W +: W];
            end else begin
                w_target_nxt[i] = r_target[i];
            end
            if (w_boundary) begin
`ifdef PWM_BANK_FADE_EN
                if (r_active[i] < r_target[i]) begin
                    w_active_nxt[i] = r_active[i] + {{(W-1){1'b0}}, 1'b1};
                end else if (r_active[i] > r_target[i]) begin
                    w_active_nxt[i] = r_active[i] - {{(W-1){1'b0}}, 1'b1};
                end else begin
                    w_active_nxt[i] = r_active[i];
                end
`else
                // Pre-edge target is used, so a LOAD on the boundary waits one more period.
                w_active_nxt[i] = r_target[i];
`endif
            end else begin
                w_active_nxt[i] = r_active[i];
            end
            w_busy_nxt = w_busy_nxt | (w_active_nxt[i] != w_target_nxt[i]);
        end
    end

    // Per-channel compare against the phase-shifted local count; offsets are fixed at elaboration.
    for (genvar g = 0; g < CH; g++) begin : g_ch
        localparam int OFF = (STAGGER != 0) ? (((g * (2**W)) / CH) % (2**W)) : 0;
        localparam logic [W-1:0] OFF_W = OFF[W-1:0];
        logic [W-1:0] w_lc;
        assign w_lc     = r_cnt + OFF_W;
        assign w_pwm[g] = (w_lc < r_active[g]);
    end

    // Shared period counter, advanced only on CE ticks.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_cnt <= '0;
        end else if (CE) begin
            r_cnt <= r_cnt + {{(W-1){1'b0}}, 1'b1};
        end else begin
            r_cnt <= r_cnt;
        end
    end

    // Duty registers: target follows LOAD, active changes only at the boundary.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_target <= '0;
            r_active <= '0;
        end else begin
            r_target <= w_target_nxt;
            r_active <= w_active_nxt;
        end
    end

    // Registered outputs; PWM_N is driven from the same compare so both edges coincide.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            PWM_P      <= '0;
            PWM_N      <= '1;
            PERIOD_END <= 1'b0;
            BUSY       <= 1'b0;
        end else begin
            PWM_P      <= w_pwm;
            PWM_N      <= ~w_pwm;
            PERIOD_END <= w_boundary;
            BUSY       <= w_busy_nxt;
        end
    end

endmodule

// File: tb/tb_m_pwm_bank.sv
// Directed self-checking bench for m_pwm_bank (CH=16, W=4): one in-phase and one staggered instance.
module tb_m_pwm_bank;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ce;
    logic        load;
    logic [63:0] dat;
    logic [63:0] dat_s;
    logic [15:0] pwm_p, pwm_n, pwm_p_s, pwm_n_s;
    logic        pe, busy, pe_s, busy_s;
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    m_pwm_bank #(.CH(16), .W(4), .STAGGER(0)) dut (
        .CLK(clk), .RST(rst_n), .CE(ce), .LOAD(load), .DAT_I(dat),
        .PWM_P(pwm_p), .PWM_N(pwm_n), .PERIOD_END(pe), .BUSY(busy)
    );

    m_pwm_bank #(.CH(16), .W(4), .STAGGER(1)) dut_s (
        .CLK(clk), .RST(rst_n), .CE(ce), .LOAD(load), .DAT_I(dat_s),
        .PWM_P(pwm_p_s), .PWM_N(pwm_n_s), .PERIOD_END(pe_s), .BUSY(busy_s)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int first, npe, nz, nb;
        rst_n = 1'b0; ce = 1'b1; load = 1'b0; dat = 64'h0; dat_s = 64'h0;
        repeat (3) @(negedge clk);
        check_val("rst_pwm_p", pwm_p, 16'h0000);
        check_val("rst_pwm_n", pwm_n, 16'hFFFF);
        check_val("rst_period_end", pe, 1'b0);
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_pwm_n_s", pwm_n_s, 16'hFFFF);

`ifdef PWM_BANK_FADE_EN
        begin
            int nerr, hi3, hi10, hi7;
            nerr = 0; hi3 = 0; hi10 = 0; hi7 = 0;
            rst_n = 1'b1; load = 1'b1; dat = 64'hA;
            step();
            load = 1'b0;
            check_val("fade_busy_load", busy, 1'b1);
            for (int p = 2; p <= 224; p++) begin
                step();
                if ((p % 16 == 0) && (p <= 160) && (busy !== ((p / 16) < 10))) nerr++;
                if (p >= 49 && p <= 64) hi3 += pwm_p[0];
                if (p >= 161 && p <= 176) hi10 += pwm_p[0];
                if (p >= 209 && p <= 224) hi7 += pwm_p[0];
                if (p == 160) check_val("fade_busy_converged", busy, 1'b0);
                if (p == 171) check_val("fade_busy_down", busy, 1'b1);
                if (p == 192) check_val("fade_busy_mid_down", busy, 1'b1);
                if (p == 208) check_val("fade_busy_down_done", busy, 1'b0);
                if (p == 170) begin load = 1'b1; dat = 64'h7; end
                if (p == 171) load = 1'b0;
            end
            check_val("fade_busy_climb", nerr, 0);
            check_val("fade_duty3", hi3, 3);
            check_val("fade_duty10", hi10, 10);
            check_val("fade_duty7", hi7, 7);
        end
`else
        begin
            int hi0, hi1, hi2, hi3, hi9, ncomp, nstag, nup, nearly, hce, npe2, j2, nchg;
            logic [15:0] prev;
            hi0 = 0; hi1 = 0; hi2 = 0; hi3 = 0; hi9 = 0; ncomp = 0; nstag = 0; nup = 0;
            nearly = 0; npe = 0;
            rst_n = 1'b1; load = 1'b1; dat = 64'h0F05; dat_s = 64'h88;
            step();
            load = 1'b0;
            check_val("busy_after_load", busy, 1'b1);
            check_val("busy_after_load_s", busy_s, 1'b1);
            for (int p = 2; p <= 112; p++) begin
                step();
                if (p <= 15) begin
                    if (pe) nearly++;
                    if (pwm_p != 16'h0) nearly++;
                end
                if (p == 16) begin
                    check_val("pe_first", pe, 1'b1);
                    check_val("busy_at_boundary", busy, 1'b0);
                    check_val("ch0_before_apply", pwm_p[0], 1'b0);
                end
                if (p == 17) check_val("ch0_first_on", pwm_p[0], 1'b1);
                if (p >= 17 && p <= 48) begin
                    hi0 += pwm_p[0]; hi1 += pwm_p[1]; hi2 += pwm_p[2];
                    npe += pe;
                    if (pwm_n !== ~pwm_p) ncomp++;
                    if (pwm_p[15:3] != 13'h0) nup++;
                    if (pwm_p_s[0] !== (((p - 1) % 16) < 8)) nstag++;
                    if (pwm_p_s[1] !== (((((p - 1) % 16) + 1) % 16) < 8)) nstag++;
                end
                if (p == 32) begin
                    check_val("stag_ch1_rise", pwm_p_s[1], 1'b1);
                    check_val("stag_ch0_low", pwm_p_s[0], 1'b0);
                end
                if (p == 33) check_val("stag_ch0_rise", pwm_p_s[0], 1'b1);
                if (p >= 81 && p <= 96) hi3 += pwm_p[0];
                if (p >= 97 && p <= 112) hi9 += pwm_p[0];
                if (p == 80) check_val("busy_load_on_boundary", busy, 1'b1);
                if (p == 96) check_val("busy_after_second_boundary", busy, 1'b0);
                if (p == 48) begin load = 1'b1; dat = 64'h0F03; end
                if (p == 49) load = 1'b0;
                if (p == 79) begin load = 1'b1; dat = 64'h0F09; end
                if (p == 80) load = 1'b0;
            end
            check_val("idle_first_period", nearly, 0);
            check_val("duty_ch0", hi0, 10);
            check_val("duty_ch1", hi1, 0);
            check_val("duty_ch2", hi2, 30);
            check_val("pe_count", npe, 2);
            check_val("pwm_n_complement", ncomp, 0);
            check_val("unused_channels_low", nup, 0);
            check_val("stagger_pattern", nstag, 0);
            check_val("boundary_load_old", hi3, 3);
            check_val("boundary_load_new", hi9, 9);

            hce = 0; npe2 = 0; first = -1; j2 = -1; nchg = 0;
            prev = pwm_p;
            for (int j = 0; j < 128; j++) begin
                ce = (j % 4 == 0);
                step();
                hce += pwm_p[0];
                if (pe) begin
                    npe2++;
                    if (first < 0) first = j; else j2 = j;
                end
                if (j > 0 && (j % 4) != 1 && pwm_p !== prev) nchg++;
                prev = pwm_p;
            end
            ce = 1'b1;
            check_val("ce_duty", hce, 72);
            check_val("ce_pe_count", npe2, 2);
            check_val("ce_period", j2 - first, 64);
            check_val("ce_stable", nchg, 0);
        end
`endif

        repeat (4) step();
        load = 1'b1; dat = 64'h1;
        step();
        load = 1'b0;
        check_val("busy_before_reset", busy, 1'b1);
        check_val("pwm_live_before_reset", (pwm_p != 16'h0), 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check_val("async_rst_pwm_p", pwm_p, 16'h0000);
        check_val("async_rst_pwm_n", pwm_n, 16'hFFFF);
        check_val("async_rst_pe", pe, 1'b0);
        check_val("async_rst_busy", busy, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        first = -1; npe = 0; nz = 0; nb = 0;
        for (int p = 1; p <= 20; p++) begin
            step();
            if (pe) begin
                npe++;
                if (first < 0) first = p;
            end
            if (pwm_p != 16'h0) nz++;
            nb += busy;
        end
        check_val("post_rst_pe_pos", first, 16);
        check_val("post_rst_pe_count", npe, 1);
        check_val("post_rst_outputs_low", nz, 0);
        check_val("post_rst_busy_low", nb, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/m_pwm_bank.md
# m_pwm_bank

Parametrised multi-channel PWM generator: the successor to the fixed 16 × 4-bit per-LED PWM instances. It owns a single shared period counter. Duty values are loaded as one packed word, and each new duty is applied glitch-free at the next period boundary. Channel phases can be staggered to spread switching current. The block sits between the shift-register pattern source and the LED pins, clocked by the system clock and paced by the clock-divider CE.

## Interface
- CH, 16, number of PWM channels (1–64)
- W, 4, duty/counter resolution in bits (2–10); period = 2^W CE ticks
- STAGGER, 1, 1 = per-channel phase offset enabled, 0 = all channels in phase

- CLK  in  1  system clock, all state on rising edge
- RST  in  1  asynchronous, active-low reset
- CE  in  1  tick enable; the counter advances only when CE=1
- LOAD  in  1  one-CLK strobe; captures DAT_I into the target registers
- DAT_I  in  CH*W  packed target duties; channel i = DAT_I[i*W+W-1 : i*W]
- PWM_P  out  CH  PWM outputs, registered
- PWM_N  out  CH  registered complement of PWM_P
- PERIOD_END  out  1  one-CLK pulse on the period boundary
- BUSY  out  1  1 while any active duty differs from its target

## Operation
- cnt (W bits): on CLK with CE=1, cnt <= cnt+1; wraps 2^W−1 → 0.
- Boundary: a CLK with CE=1 and cnt==2^W−1.
- target[i] (W bits): on LOAD=1, target[i] <= DAT_I slice i. It is held otherwise.
- active[i] (W bits): updated only on a boundary, from the target value present before that edge.
- LOAD coincident with a boundary: the new DAT_I reaches target that cycle. active takes the previous target, so the new value applies at the following boundary.
- Phase offset: off_i = STAGGER ? ((i·2^W)/CH) mod 2^W : 0, using integer division and computed at elaboration.
- Local count: lc_i = (cnt + off_i) mod 2^W.
- Each CLK (not CE-gated): PWM_P[i] <= (lc_i < active[i]), and PWM_N[i] <= ~(lc_i < active[i]).
- Duty 0 gives a constant low output. Duty d gives high for exactly d of 2^W CE ticks. Maximum duty is (2^W−1)/2^W; full-on is not reachable by design.
- PERIOD_END <= boundary, registered.
- BUSY <= OR over i of (active[i] != target[i]), evaluated on the next-state values.
- Reset (any time, including mid-period or mid-fade):
  - cnt, target, active, PWM_P, PERIOD_END and BUSY are cleared to 0.
  - PWM_N is set to all ones.
  - The first period after reset release starts at cnt=0.

## Timing
- PWM_P and PWM_N lag cnt by 1 CLK, with identical edge timing on both.
- DAT_I → target: 1 CLK after LOAD.
- target → output:
  - Takes effect at the first boundary after the LOAD edge.
  - Becomes visible on PWM_P 1 CLK after that boundary.
  - Worst case is 2^W CE ticks + 2 CLK.
- CE tied high: period = 2^W CLK. CE gaps freeze cnt and the outputs, without glitches.
- PERIOD_END is high for exactly 1 CLK per period, on the CLK after the boundary edge.
- LOAD does not need CE and may be issued back-to-back; the last LOAD before a boundary wins.

## Configuration
- PWM_BANK_FADE_EN defined: at each boundary, active[i] steps ±1 toward target[i], or holds if equal. A 0 → d change takes d periods. BUSY stays high until every channel has converged.
- PWM_BANK_FADE_EN undefined: at each boundary, active[i] <= target[i] directly. BUSY is high only from LOAD until the next boundary.

## Test plan
- Reset value and clearing:
  - Stimulus: CH=16, W=4, STAGGER=0, CE=1; assert RST low mid-period with loaded duties.
  - Required: PWM_P=0x0000, PWM_N=0xFFFF, PERIOD_END=0 and BUSY=0 immediately (asynchronous).
  - After release, the first PERIOD_END comes 16 CLK later (+1 registered).
- Duty accuracy:
  - Stimulus: LOAD ch0=5, ch1=0, ch2=15; then run 2 periods.
  - Required: ch0 high 5/16 ticks, ch1 constant low, ch2 low exactly 1 tick per period.
  - Each new value first appears 1 CLK after the first boundary following LOAD.
- LOAD on boundary (no fade):
  - Stimulus: target ch0=3; LOAD ch0=9 on the same edge as the boundary.
  - Required: the next period uses 3, the one after uses 9.
- Stagger:
  - Stimulus: STAGGER=1, ch0=ch1=8.
  - Required: ch1 rises at cnt=15 and ch0 at cnt=0, i.e. 1 tick apart; ch1 is high for cnt 15, 0–6.
- CE gating:
  - Stimulus: CE high 1 CLK in 4.
  - Required: period = 64 CLK; outputs are stable between CE pulses; duty ratio is unchanged.
- Fade (PWM_BANK_FADE_EN):
  - Stimulus: ch0 0→10, then 10→7.
  - Required: active climbs 1 per period and reaches 10 after 10 boundaries, with BUSY falling on that boundary. It then descends to 7 in 3 periods.
